// File: rtl/full_adder.sv
// full_adder
// Registered ripple-carry adder: {cout, sum} = a + b + cin, one cycle of
// latency, one operation per cycle. At WIDTH=1 it is a registered single-bit
// full adder.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   a, b      in   WIDTH-bit operands (unsigned or two's complement)
//   cin       in   carry into bit 0
//   in_valid  in   operands are sampled at this edge
//   sum       out  registered WIDTH-bit sum
//   cout      out  registered carry out of the MSB
//   ovf       out  registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid out  sum/cout/ovf carry a new result this cycle
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             valid_reg;

  // One full-adder cell per bit. Each cell owns its carry-in/carry-out nets
  // and takes its carry-in from the previous cell, so the ripple chain is a
  // plain sequence of distinct nets rather than one vector feeding itself.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic c_in;
    logic c_out;

    if (gi == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_rest
      assign c_in = g_cell[gi-1].c_out;
    end

    assign sum_next[gi] = a[gi] ^ b[gi] ^ c_in;
    assign c_out        = (a[gi] & b[gi]) | (c_in & (a[gi] ^ b[gi]));
  end

  assign cout_next = g_cell[WIDTH-1].c_out;
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf_next  = g_cell[WIDTH-1].c_in ^ g_cell[WIDTH-1].c_out;

  // Result registers load only on a valid edge, so don't-care (even X)
  // operands presented while in_valid is low never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        ovf_reg  <= ovf_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder: three instances (WIDTH 1, 8, 16) share clock and
// reset. A behavioural model (plain integer arithmetic) predicts every
// instance's outputs each cycle; directed tests add constant expectations.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a1, b1, c1, v1;
  logic        sum1, cout1, ovf1, valid1;
  logic [7:0]  a8, b8;
  logic        c8, v8;
  logic [7:0]  sum8;
  logic        cout8, ovf8, valid8;
  logic [15:0] a16, b16;
  logic        c16, v16;
  logic [15:0] sum16;
  logic        cout16, ovf16, valid16;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .out_valid(valid1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .out_valid(valid8)
  );

  full_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .in_valid(v16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .out_valid(valid16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, index 0/1/2 = WIDTH 1/8/16.
  int      wd [3] = '{1, 8, 16};
  longint  m_sum   [3];
  bit      m_cout  [3];
  bit      m_ovf   [3];
  bit      m_valid [3];

  // Arithmetic view of the result: unsigned sum for sum/cout, signed sum
  // range check for ovf.
  function automatic void model_step(int k, bit r, bit v, longint a, longint b, bit c);
    longint mask, full, half, sa, sb, ss;
    if (r) begin
      m_sum[k] = 0; m_cout[k] = 0; m_ovf[k] = 0; m_valid[k] = 0;
      return;
    end
    m_valid[k] = v;
    if (!v) return;
    mask = (longint'(1) << wd[k]) - 1;
    half = longint'(1) << (wd[k] - 1);
    a = a & mask;
    b = b & mask;
    full = a + b + longint'(c);
    m_sum[k]  = full & mask;
    m_cout[k] = ((full >> wd[k]) & 1) != 0;
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    ss = sa + sb + longint'(c);
    m_ovf[k] = (ss > half - 1) || (ss < -half);
  endfunction

  // One clock: capture the inputs in force at the edge, advance the model,
  // then compare every instance's outputs 1 time unit after the edge.
  task automatic tick();
    bit r;
    bit iv1, ia1, ib1, ic1, iv8, ic8, iv16, ic16;
    logic [7:0]  ia8, ib8;
    logic [15:0] ia16, ib16;
    r = rst;
    iv1 = v1; ia1 = a1; ib1 = b1; ic1 = c1;
    iv8 = v8; ia8 = a8; ib8 = b8; ic8 = c8;
    iv16 = v16; ia16 = a16; ib16 = b16; ic16 = c16;
    @(posedge clk);
    model_step(0, r, iv1, longint'(ia1), longint'(ib1), ic1);
    model_step(1, r, iv8, longint'(ia8), longint'(ib8), ic8);
    model_step(2, r, iv16, longint'(ia16), longint'(ib16), ic16);
    #1;
    check_eq("m1_sum",    sum1,    m_sum[0]);
    check_eq("m1_cout",   cout1,   m_cout[0]);
    check_eq("m1_ovf",    ovf1,    m_ovf[0]);
    check_eq("m1_valid",  valid1,  m_valid[0]);
    check_eq("m8_sum",    sum8,    m_sum[1]);
    check_eq("m8_cout",   cout8,   m_cout[1]);
    check_eq("m8_ovf",    ovf8,    m_ovf[1]);
    check_eq("m8_valid",  valid8,  m_valid[1]);
    check_eq("m16_sum",   sum16,   m_sum[2]);
    check_eq("m16_cout",  cout16,  m_cout[2]);
    check_eq("m16_ovf",   ovf16,   m_ovf[2]);
    check_eq("m16_valid", valid16, m_valid[2]);
  endtask

  logic [1:0] w1_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [2:0] abc;
    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;
    #1;
    tick();
    tick();
    check_eq("rst_sum16",   sum16,   64'd0);
    check_eq("rst_valid16", valid16, 64'd0);
    check_eq("rst_cout8",   cout8,   64'd0);

    // WIDTH=1 exhaustive, back-to-back
    rst = 1'b0;
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a1, b1, c1} = abc;
      tick();
      check_eq($sformatf("w1_exh%0d", i), {cout1, sum1}, w1_tab[i]);
      check_eq("w1_exh_valid", valid1, 64'd1);
    end

    // Reset wins over a valid operation on the same edge
    a1 = 1; b1 = 1; c1 = 1; v1 = 1; rst = 1'b1;
    tick();
    check_eq("w1_rst_out",   {ovf1, cout1, sum1}, 64'd0);
    check_eq("w1_rst_valid", valid1, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("w1_post_rst", {valid1, cout1, sum1}, 64'b111);

    // Hold with in_valid low
    a1 = 1; b1 = 0; c1 = 0; v1 = 1;
    tick();
    check_eq("w1_hold_load", {cout1, sum1}, 64'b01);
    a1 = 1; b1 = 1; c1 = 1; v1 = 0;
    tick();
    check_eq("w1_hold_val",   {cout1, sum1}, 64'b01);
    check_eq("w1_hold_valid", valid1, 64'd0);

    // WIDTH=8 wrap-around and carry-in
    v8 = 1; a8 = 8'hFF; b8 = 8'h01; c8 = 0;
    tick();
    check_eq("w8_wrap_sum", sum8, 64'h00);
    check_eq("w8_wrap_co",  {cout8, ovf8}, 64'b10);
    a8 = 8'h7F;
    tick();
    check_eq("w8_ovf_sum", sum8, 64'h80);
    check_eq("w8_ovf_co",  {cout8, ovf8}, 64'b01);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    tick();
    check_eq("w8_cin_sum", sum8, 64'hFF);
    check_eq("w8_cin_co",  {cout8, ovf8, valid8}, 64'b101);
    v8 = 0;

    // WIDTH=16 random stream with interleaved reset pulses
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      v16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    v16 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
